// File: rtl/seq_calculator.sv
// Sequential signed calculator: one-cycle add/sub, shift-add multiply and restoring divide.
// Define SEQ_CALC_SAT_EN to clamp overflowing results to the WIDTH-bit signed range.
module seq_calculator #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] result,
    output logic signed [WIDTH-1:0]   remainder,
    output logic                      overflow,
    output logic                      div_by_zero
);
    localparam int W2 = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    step;

    logic [1:0]              op_r;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic [W2-1:0]           acc;
    logic [W2-1:0]           mcand;
    logic [WIDTH-1:0]        mplier;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        rem_r;
    logic                    neg_q;
    logic                    neg_r;
    logic                    dbz_r;

    logic [WIDTH:0]          trial;
    logic                    div_bit;
    logic [WIDTH-1:0]        rem_nx;

    logic [W2-1:0]           q_ext;
    logic [W2-1:0]           exact;
    logic [W2-1:0]           res_fmt;
    logic [WIDTH-1:0]        rem_fmt;
    logic                    ovf_fmt;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    function automatic logic [W2-1:0] sext(input logic signed [WIDTH-1:0] x);
        return {{WIDTH{x[WIDTH-1]}}, x};
    endfunction

    // A value fits WIDTH signed bits when its top WIDTH+1 bits are all copies of the sign.
    function automatic logic fits(input logic [W2-1:0] x);
        return x[W2-1:WIDTH-1] == {(WIDTH+1){x[W2-1]}};
    endfunction

`ifdef SEQ_CALC_SAT_EN
    function automatic logic [W2-1:0] sat_limit(input logic neg);
        return neg ? {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}}
                   : {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign step      = (state == CALC) && (cnt != '0);

    // Restoring divide step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        trial   = {rem_r, quo[WIDTH-1]};
        div_bit = (trial >= {1'b0, mplier});
        rem_nx  = div_bit ? WIDTH'(trial - {1'b0, mplier}) : trial[WIDTH-1:0];
    end

    always_comb begin
        q_ext   = {{WIDTH{1'b0}}, quo};
        exact   = acc;
        rem_fmt = '0;
        case (op_r)
            OP_MUL: exact = neg_q ? -acc : acc;
            OP_DIV: begin
                if (dbz_r) begin
                    exact   = '0;
                    rem_fmt = a_r;
                end else begin
                    exact   = neg_q ? -q_ext : q_ext;
                    rem_fmt = neg_r ? -rem_r : rem_r;
                end
            end
            default: ;
        endcase
        ovf_fmt = !fits(exact);
`ifdef SEQ_CALC_SAT_EN
        res_fmt = ovf_fmt ? sat_limit(exact[W2-1]) : exact;
`else
        res_fmt = exact;
`endif
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            result      <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state       <= CALC;
                    cnt         <= (op == OP_MUL || (op == OP_DIV && b != '0)) ? CNT_W'(WIDTH)
                                                                             : CNT_W'(1);
                    result      <= '0;
                    remainder   <= '0;
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                CALC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        result      <= res_fmt;
                        remainder   <= rem_fmt;
                        overflow    <= ovf_fmt;
                        div_by_zero <= dbz_r;
                        state       <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r  <= a[WIDTH-1];
            dbz_r  <= (op == OP_DIV) && (b == '0);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, magnitude(a)};
            mplier <= magnitude(b);
            quo    <= magnitude(a);
            rem_r  <= '0;
        end else if (step) begin
            case (op_r)
                OP_ADD: acc <= sext(a_r) + sext(b_r);
                OP_SUB: acc <= sext(a_r) - sext(b_r);
                OP_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                OP_DIV: if (!dbz_r) begin
                    rem_r <= rem_nx;
                    quo   <= {quo[WIDTH-2:0], div_bit};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, sequential, signed integer calculator.
- Generalises the fixed-width combinational add/sub/multiply unit to WIDTH-bit two's-complement operands.
- Adds an iterative shift-add multiplier and a restoring divider with quotient and remainder.
- Sits between the host-side operand/opcode interface and result formatting; valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand width in bits, two's complement; legal range 4..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept a command.
- op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- a  in  WIDTH  signed operand A (dividend for div).
- b  in  WIDTH  signed operand B (divisor for div).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  signed result: sum, difference, product or quotient, sign-extended.
- remainder  out  WIDTH  signed remainder for div; 0 for other ops.
- overflow  out  1  true result lies outside the WIDTH-bit signed range.
- div_by_zero  out  1  div issued with b == 0.

Behaviour:
- Reset (async assert, sync deassert at the next clk edge): state=IDLE; in_ready=1 the cycle after reset releases; out_valid=0; result=0; remainder=0; overflow=0; div_by_zero=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch op, a and b, and go to CALC.
  - Operands also captured in magnitude form, with sign_a, sign_b and the result sign.
- CALC, add/sub:
  - One cycle: 2*WIDTH-bit sign-extended add or subtract, then DONE.
- CALC, mul:
  - WIDTH iterations, one bit per cycle, LSB first.
  - Each cycle: if the current multiplier bit is 1, accumulator += |a| << i.
  - After the last iteration, negate the product if sign_a ^ sign_b, then DONE.
- CALC, div:
  - Restoring division on |a| / |b|, WIDTH iterations, MSB first.
  - Quotient sign is sign_a ^ sign_b; remainder sign follows sign_a (truncating division, C semantics).
- CALC, div with b == 0:
  - One cycle only: result=0, remainder=a, div_by_zero=1, overflow=0, then DONE.
- DONE:
  - out_valid=1; result, remainder and flags are held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Handshake:
  - in_ready=0 outside IDLE, so a new command is never accepted while one is in flight.
  - in_valid, op, a and b are don't-care when in_ready=0.
  - The first command is accepted the cycle after DONE exits (one bubble cycle).
- Latency, accept edge to first cycle out_valid is high:
  - add, sub, div-by-zero: 2 cycles.
  - mul, div: WIDTH+1 cycles.
- overflow rules:
  - add/sub: true result outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - mul: same range test on the product.
  - div: set only for -2^(WIDTH-1) / -1.
  - The 2*WIDTH result always carries the exact value.
- remainder=0 for add, sub and mul.
- Reset mid-operation: returns to IDLE immediately; the in-flight command is discarded; no out_valid is produced.
- Flags are cleared when a new command is accepted.

Optional Feature:
- Macro: SEQ_CALC_SAT_EN.
- Defined:
  - When overflow=1, result is clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1), sign-extended to 2*WIDTH; the overflow flag is still asserted.
  - Div-by-zero output is unchanged.
- Undefined: result is always the exact 2*WIDTH-bit value.

Test Plan:
- WIDTH=8, add a=100, b=50 -> result=16'h0096 (150), overflow=1, out_valid 2 cycles after accept; with SEQ_CALC_SAT_EN -> result=16'h007F.
- WIDTH=8, sub a=-5, b=7 -> result=16'hFFF4 (-12), overflow=0; mul a=-7, b=15 -> result=16'hFF97 (-105), out_valid exactly 9 cycles after accept.
- WIDTH=8, mul a=-128, b=-128 -> result=16'h4000, overflow=1; div a=-128, b=-1 -> result=16'h0080, remainder=0, overflow=1.
- WIDTH=8, div a=-17, b=5 -> result=-3 (16'hFFFD), remainder=-2 (8'hFE); div a=17, b=0 -> result=0, remainder=17, div_by_zero=1, latency 2.
- Hold out_ready=0 for 5 cycles after a mul completes -> out_valid and result stable and in_ready=0 throughout; a command presented with in_valid during the stall is not accepted.
- Assert rst_n=0 on the 4th CALC cycle of a div -> all outputs at reset values; no out_valid after release; the next add completes normally.
